// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution path: op codes, operand widths and
// the queued op payload.
package alu_pkg;

  localparam int unsigned OP_W          = 5;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned ROB_W_DEFAULT = 5;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD   = 5'd0;
  localparam alu_op_t ALU_OP_SUB   = 5'd1;
  localparam alu_op_t ALU_OP_AND   = 5'd2;
  localparam alu_op_t ALU_OP_OR    = 5'd3;
  localparam alu_op_t ALU_OP_XOR   = 5'd4;
  localparam alu_op_t ALU_OP_SLL   = 5'd5;
  localparam alu_op_t ALU_OP_SRL   = 5'd6;
  localparam alu_op_t ALU_OP_SRA   = 5'd7;
  localparam alu_op_t ALU_OP_SLT   = 5'd8;
  localparam alu_op_t ALU_OP_SLTU  = 5'd9;
  localparam alu_op_t ALU_OP_ADDI  = 5'd10;
  localparam alu_op_t ALU_OP_ANDI  = 5'd11;
  localparam alu_op_t ALU_OP_ORI   = 5'd12;
  localparam alu_op_t ALU_OP_XORI  = 5'd13;
  localparam alu_op_t ALU_OP_SLLI  = 5'd14;
  localparam alu_op_t ALU_OP_SRLI  = 5'd15;
  localparam alu_op_t ALU_OP_SRAI  = 5'd16;
  localparam alu_op_t ALU_OP_SLTI  = 5'd17;
  localparam alu_op_t ALU_OP_SLTIU = 5'd18;
  localparam alu_op_t ALU_OP_BEQ   = 5'd19;
  localparam alu_op_t ALU_OP_BNE   = 5'd20;
  localparam alu_op_t ALU_OP_BLT   = 5'd21;
  localparam alu_op_t ALU_OP_BGE   = 5'd22;
  localparam alu_op_t ALU_OP_BLTU  = 5'd23;
  localparam alu_op_t ALU_OP_BGEU  = 5'd24;

  localparam alu_op_t IMM_FORM_LO = ALU_OP_ADDI;
  localparam alu_op_t IMM_FORM_HI = ALU_OP_SLTIU;

  // I-forms take their second operand from the immediate field
  function automatic logic is_imm_form(alu_op_t op);
    return (op >= IMM_FORM_LO) && (op <= IMM_FORM_HI);
  endfunction

  typedef struct packed {
    alu_op_t         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } alu_payload_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue-side and CDB-side signal bundle between reservation station and the
// ALU execution unit.
interface alu_exec_unit_if #(
  parameter int unsigned ROB_W = alu_pkg::ROB_W_DEFAULT
);
  import alu_pkg::*;

  logic              _clear;
  logic              _alu_ready;
  alu_op_t           _alu_type;
  logic [ROB_W-1:0]  _alu_rob_id;
  logic [XLEN-1:0]   _alu_r1;
  logic [XLEN-1:0]   _alu_r2;
  logic [XLEN-1:0]   _alu_imm;
  logic              _alu_full;
  logic              _cdb_ready;
  logic [ROB_W-1:0]  _cdb_rob_id;
  logic [XLEN-1:0]   _cdb_value;

  modport master (
    output _clear, _alu_ready, _alu_type, _alu_rob_id, _alu_r1, _alu_r2, _alu_imm,
    input  _alu_full, _cdb_ready, _cdb_rob_id, _cdb_value
  );

  modport slave (
    input  _clear, _alu_ready, _alu_type, _alu_rob_id, _alu_r1, _alu_r2, _alu_imm,
    output _alu_full, _cdb_ready, _cdb_rob_id, _cdb_value
  );

endinterface

// File: rtl/alu_core.sv
// Combinational integer/branch evaluator: (op, a, b) -> 32-bit value.
// Branch compares yield 1 for taken, 0 for not taken.
module alu_core
  import alu_pkg::*;
(
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] value
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    value = '0;
    case (op)
      ALU_OP_ADD,  ALU_OP_ADDI:  value = a + b;
      ALU_OP_SUB:                value = a - b;
      ALU_OP_AND,  ALU_OP_ANDI:  value = a & b;
      ALU_OP_OR,   ALU_OP_ORI:   value = a | b;
      ALU_OP_XOR,  ALU_OP_XORI:  value = a ^ b;
      ALU_OP_SLL,  ALU_OP_SLLI:  value = a << shamt;
      ALU_OP_SRL,  ALU_OP_SRLI:  value = a >> shamt;
      ALU_OP_SRA,  ALU_OP_SRAI:  value = XLEN'($signed(a) >>> shamt);
      ALU_OP_SLT,  ALU_OP_SLTI:  value = XLEN'($signed(a) < $signed(b));
      ALU_OP_SLTU, ALU_OP_SLTIU: value = XLEN'(a < b);
      ALU_OP_BEQ:                value = XLEN'(a == b);
      ALU_OP_BNE:                value = XLEN'(a != b);
      ALU_OP_BLT:                value = XLEN'($signed(a) < $signed(b));
      ALU_OP_BGE:                value = XLEN'($signed(a) >= $signed(b));
      ALU_OP_BLTU:               value = XLEN'(a < b);
      ALU_OP_BGEU:               value = XLEN'(a >= b);
      default:                   value = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: in-order issue queue feeding alu_core, one result per
// cycle registered onto the ALU CDB channel.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROB_W = ROB_W_DEFAULT
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  alu_exec_unit_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  alu_payload_t     pay_q [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             push;
  logic             pop;
  alu_payload_t     head_pay;
  logic [XLEN-1:0]  head_result;

  assign bus._alu_full = (count == CNT_W'(DEPTH));

  // Clear outranks both queue operations; full blocks a push even when popping
  assign push = rdy_in & bus._alu_ready & ~bus._alu_full & ~bus._clear;
  assign pop  = rdy_in & ~bus._clear & (count != '0);

  assign head_pay = pay_q[head];

  alu_core u_core (
    .op    (head_pay.op),
    .a     (head_pay.a),
    .b     (head_pay.b),
    .value (head_result)
  );

  // Payload storage carries no reset; validity is tracked by count
  always_ff @(posedge clk_in) begin
    if (push) begin
      pay_q[tail] <= '{op: bus._alu_type,
                       a:  bus._alu_r1,
                       b:  is_imm_form(bus._alu_type) ? bus._alu_imm : bus._alu_r2};
      rob_q[tail] <= bus._alu_rob_id;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (bus._clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // CDB register: tag and value hold between broadcasts
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus._cdb_ready  <= 1'b0;
      bus._cdb_rob_id <= '0;
      bus._cdb_value  <= '0;
    end else if (rdy_in) begin
      bus._cdb_ready <= pop;
      if (pop) begin
        bus._cdb_rob_id <= rob_q[head];
        bus._cdb_value  <= head_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios then randomized traffic, all
// checked against a queue-based reference model.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 5;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.ROB_W(RW)) bus ();

  alu_exec_unit #(.DEPTH(DEPTH), .ROB_W(RW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [RW-1:0] rob;
    logic [31:0]   val;
  } res_t;

  res_t          mq[$];
  logic          e_ready;
  logic [RW-1:0] e_rob;
  logic [31:0]   e_val;

  // Expected result straight from the op-code table
  function automatic logic [31:0] ref_value(logic [4:0] op, logic [31:0] a,
                                            logic [31:0] r2, logic [31:0] imm);
    logic [31:0] b;
    logic [31:0] ones;
    int          sh;
    int          sa;
    int          sb;
    b    = (op >= 5'd10 && op <= 5'd18) ? imm : r2;
    ones = '1;
    sh   = int'(b[4:0]);
    sa   = a;
    sb   = b;
    case (op)
      5'd0, 5'd10:  return a + b;
      5'd1:         return a - b;
      5'd2, 5'd11:  return a & b;
      5'd3, 5'd12:  return a | b;
      5'd4, 5'd13:  return a ^ b;
      5'd5, 5'd14:  return a << sh;
      5'd6, 5'd15:  return a >> sh;
      5'd7, 5'd16:  return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
      5'd8, 5'd17:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd9, 5'd18:  return (a < b) ? 32'd1 : 32'd0;
      5'd19:        return (a == b) ? 32'd1 : 32'd0;
      5'd20:        return (a != b) ? 32'd1 : 32'd0;
      5'd21:        return (sa < sb) ? 32'd1 : 32'd0;
      5'd22:        return (sa >= sb) ? 32'd1 : 32'd0;
      5'd23:        return (a < b) ? 32'd1 : 32'd0;
      5'd24:        return (a >= b) ? 32'd1 : 32'd0;
      default:      return 32'd0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(int unsigned op, int unsigned rob, logic [31:0] a,
                       logic [31:0] r2, logic [31:0] imm);
    bus._alu_ready  = 1'b1;
    bus._alu_type   = 5'(op);
    bus._alu_rob_id = RW'(rob);
    bus._alu_r1     = a;
    bus._alu_r2     = r2;
    bus._alu_imm    = imm;
  endtask

  task automatic idle();
    bus._alu_ready = 1'b0;
  endtask

  task automatic check_cdb(string tag);
    chk({tag, "_ready"}, 32'(bus._cdb_ready), 32'(e_ready));
    chk({tag, "_rob"},   32'(bus._cdb_rob_id), 32'(e_rob));
    chk({tag, "_value"}, bus._cdb_value, e_val);
  endtask

  // One clock: check full before the edge, advance the model, check the CDB after
  task automatic cycle();
    int   sz;
    res_t r;
    logic iss;
    iss = bus._alu_ready;
    chk("alu_full", 32'(bus._alu_full), (mq.size() == DEPTH) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (rdy) begin
      if (bus._clear) begin
        mq.delete();
        e_ready = 1'b0;
      end else begin
        sz = mq.size();
        if (sz > 0) begin
          r       = mq.pop_front();
          e_ready = 1'b1;
          e_rob   = r.rob;
          e_val   = r.val;
        end else begin
          e_ready = 1'b0;
        end
        if (iss && sz < DEPTH) begin
          r.rob = bus._alu_rob_id;
          r.val = ref_value(bus._alu_type, bus._alu_r1, bus._alu_r2, bus._alu_imm);
          mq.push_back(r);
        end
      end
    end
    #1;
    check_cdb("cdb");
  endtask

  task automatic do_reset();
    idle();
    bus._clear = 1'b0;
    rst = 1'b1;
    #2;
    mq.delete();
    e_ready = 1'b0;
    e_rob   = '0;
    e_val   = '0;
    check_cdb("rst");
    chk("rst_full", 32'(bus._alu_full), 32'd0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst             = 1'b1;
    rdy             = 1'b1;
    bus._clear      = 1'b0;
    bus._alu_ready  = 1'b0;
    bus._alu_type   = '0;
    bus._alu_rob_id = '0;
    bus._alu_r1     = '0;
    bus._alu_r2     = '0;
    bus._alu_imm    = '0;
    e_ready         = 1'b0;
    e_rob           = '0;
    e_val           = '0;
    do_reset();

    // ADD wraps to 1, visible one edge after acceptance for one cycle
    issue(0, 3, 32'hFFFF_FFFF, 32'd2, 32'h0000_1234);
    cycle();
    chk("add_not_yet", 32'(bus._cdb_ready), 32'd0);
    idle();
    cycle();
    chk("add_ready", 32'(bus._cdb_ready), 32'd1);
    chk("add_rob", 32'(bus._cdb_rob_id), 32'd3);
    chk("add_value", bus._cdb_value, 32'd1);
    cycle();
    chk("add_gone", 32'(bus._cdb_ready), 32'd0);

    // Back-to-back SRAI / BLTU / BLT
    issue(16, 1, 32'h8000_0000, 32'h0000_001F, 32'd4);
    cycle();
    issue(23, 2, 32'd1, 32'hFFFF_FFFF, 32'd0);
    cycle();
    chk("srai_rob", 32'(bus._cdb_rob_id), 32'd1);
    chk("srai_value", bus._cdb_value, 32'hF800_0000);
    issue(21, 4, 32'd1, 32'hFFFF_FFFF, 32'd0);
    cycle();
    chk("bltu_rob", 32'(bus._cdb_rob_id), 32'd2);
    chk("bltu_value", bus._cdb_value, 32'd1);
    idle();
    cycle();
    chk("blt_ready", 32'(bus._cdb_ready), 32'd1);
    chk("blt_rob", 32'(bus._cdb_rob_id), 32'd4);
    chk("blt_value", bus._cdb_value, 32'd0);
    cycle();

    // Five consecutive issues stream through and wrap the pointers
    for (int i = 0; i < 5; i++) begin
      issue($urandom_range(0, 24), 8 + i, pick_operand(), pick_operand(), pick_operand());
      cycle();
      chk("stream_not_full", 32'(bus._alu_full), 32'd0);
    end
    idle();
    cycle();
    cycle();

    // Freeze with an op pending; an issue during the freeze is not taken
    issue(1, 20, 32'd10, 32'd3, 32'd0);
    cycle();
    issue(4, 21, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'd0);
    cycle();
    rdy = 1'b0;
    issue(0, 22, 32'd5, 32'd5, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("freeze_rob", 32'(bus._cdb_rob_id), 32'd20);
    end
    rdy = 1'b1;
    idle();
    cycle();
    chk("thaw_rob", 32'(bus._cdb_rob_id), 32'd21);
    chk("thaw_value", bus._cdb_value, 32'hF0F0_0F0F);
    cycle();
    cycle();

    // Clear with an op queued plus a same-cycle issue: neither tag appears
    issue(0, 30, 32'd1, 32'd1, 32'd0);
    cycle();
    bus._clear = 1'b1;
    issue(0, 31, 32'd2, 32'd2, 32'd0);
    cycle();
    chk("clear_ready", 32'(bus._cdb_ready), 32'd0);
    bus._clear = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("clear_quiet", 32'(bus._cdb_ready), 32'd0);
    end

    // Reset with an op pending, then normal latency afterwards
    issue(2, 12, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0);
    cycle();
    do_reset();
    issue(10, 13, 32'd100, 32'd0, 32'hFFFF_FFFF);
    cycle();
    chk("post_rst_wait", 32'(bus._cdb_ready), 32'd0);
    idle();
    cycle();
    chk("post_rst_rob", 32'(bus._cdb_rob_id), 32'd13);
    chk("post_rst_value", bus._cdb_value, 32'd99);

    // Randomized traffic including freezes and flushes
    for (int i = 0; i < 400; i++) begin
      rdy        = ($urandom_range(0, 9) != 0);
      bus._clear = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 6 && mq.size() < DEPTH)
        issue($urandom_range(0, 31), $urandom_range(0, 31),
              pick_operand(), pick_operand(), pick_operand());
      else
        idle();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
